deinterleaver_44bit_stream: RTL



---
 rtl/deintlv_pkg.sv | 19 +
 rtl/deinterleaver_44bit_stream_if.sv | 37 +++
 rtl/deinterleaver_44bit_stream_bank.sv | 25 ++
 rtl/deinterleaver_44bit_stream.sv | 96 +++++++++
 4 files changed

// File: rtl/deintlv_pkg.sv
// Shared geometry and index map for the 44-bit stream deinterleaver.
// Optional framing (s_sof / sync_err) is enabled by defining DEINTLV_SYNC_EN.
package deintlv_pkg;

    localparam int ROWS    = 4;
    localparam int COLS    = 11;
    localparam int FRAME_W = ROWS * COLS;
    localparam int CNT_W   = 6;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_W - 1);

    // Received bit n = ROWS*k + j lands on word bit COLS*j + k.
    function automatic logic [CNT_W-1:0] deintlv_idx(input logic [CNT_W-1:0] n);
        int unsigned ni;
        ni = 32'(n);
        return CNT_W'(COLS * (ni % ROWS) + ni / ROWS);
    endfunction

endpackage

// File: rtl/deinterleaver_44bit_stream_if.sv
// Serial-in / word-out bus of the deinterleaver.
// Carries s_sof and sync_err only when DEINTLV_SYNC_EN is defined.
interface deinterleaver_44bit_stream_if;
    import deintlv_pkg::*;

    logic               s_valid;
    logic               s_ready;
    logic               s_bit;
    logic               m_valid;
    logic               m_ready;
    logic [FRAME_W-1:0] m_data;
`ifdef DEINTLV_SYNC_EN
    logic               s_sof;
    logic               sync_err;

    modport master (
        output s_valid, s_bit, s_sof, m_ready,
        input  s_ready, m_valid, m_data, sync_err
    );

    modport slave (
        input  s_valid, s_bit, s_sof, m_ready,
        output s_ready, m_valid, m_data, sync_err
    );
`else
    modport master (
        output s_valid, s_bit, m_ready,
        input  s_ready, m_valid, m_data
    );

    modport slave (
        input  s_valid, s_bit, m_ready,
        output s_ready, m_valid, m_data
    );
`endif

endinterface

// File: rtl/deinterleaver_44bit_stream_bank.sv
// One 44-bit word buffer: single-bit scatter write with synchronous clear.
module deintlv_bank
    import deintlv_pkg::*;
(
    input  logic               clk,
    input  logic               clr,
    input  logic               we,
    input  logic [CNT_W-1:0]   idx,
    input  logic               din,
    output logic [FRAME_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else begin
            for (int i = 0; i < FRAME_W; i++) begin
                if (we && idx == CNT_W'(i)) begin
                    q[i] <= din;
                end
            end
        end
    end

endmodule

// File: rtl/deinterleaver_44bit_stream.sv
// Ping-pong serial-to-word deinterleaver feeding the Hamming decoder.
// Define DEINTLV_SYNC_EN to add start-of-frame resync (s_sof) and the sync_err pulse.
module deinterleaver_44bit_stream
    import deintlv_pkg::*;
(
    input logic clk,
    input logic rst,
    deinterleaver_44bit_stream_if.slave bus
);

    logic [1:0]         full;
    logic [1:0]         full_nxt;
    logic               wr_sel;
    logic               rd_sel;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_eff;
    logic [CNT_W-1:0]   wr_idx;
    logic               accept;
    logic               rel_word;
    logic               frame_done;
    logic [FRAME_W-1:0] bank_q [2];

    assign bus.s_ready = !full[wr_sel];
    assign bus.m_valid = full[rd_sel];
    assign bus.m_data  = bank_q[rd_sel];

    assign accept   = bus.s_valid && bus.s_ready && !rst;
    assign rel_word = bus.m_valid && bus.m_ready;

`ifdef DEINTLV_SYNC_EN
    logic resync;
    logic sync_err_q;

    // A start-of-frame mid-count abandons the partial frame and restarts at n=0.
    assign resync  = accept && bus.s_sof && (cnt != '0);
    assign cnt_eff = resync ? '0 : cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_err_q <= 1'b0;
        end else begin
            sync_err_q <= resync;
        end
    end

    assign bus.sync_err = sync_err_q;
`else
    assign cnt_eff = cnt;
`endif

    assign wr_idx     = deintlv_idx(cnt_eff);
    assign frame_done = accept && (cnt_eff == LAST_IDX);

    // Fill and release always target different banks, so both may land together.
    always_comb begin
        full_nxt = full;
        if (frame_done) begin
            full_nxt[wr_sel] = 1'b1;
        end
        if (rel_word) begin
            full_nxt[rd_sel] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            full   <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            full <= full_nxt;
            if (accept) begin
                cnt <= frame_done ? '0 : cnt_eff + CNT_W'(1);
            end
            if (frame_done) begin
                wr_sel <= ~wr_sel;
            end
            if (rel_word) begin
                rd_sel <= ~rd_sel;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        deintlv_bank u_bank (
            .clk (clk),
            .clr (rst),
            .we  (accept && (wr_sel == 1'(b))),
            .idx (wr_idx),
            .din (bus.s_bit),
            .q   (bank_q[b])
        );
    end

endmodule
